// File: rtl/reg_dump_pkg.sv
// Shared types for the register-file dump/load controller.
// Holds the FSM state encoding and the zero-register index.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    OUT_HOLD = 3'd3,
    LOAD     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/reg_dump_ctrl.sv
// Dump/load controller for the LEGv8 register file ports.
// Ports: clk, reset (async active-low), start_dump/start_load/abort
//   controls, ra1/rd1 read port, we3/wa3/wd3 write port,
//   dout_* dump stream (valid/ready), din_* load stream
//   (valid/ready), busy and a one-cycle done pulse.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int N_REGS   = 31,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_dump,
  input  logic              start_load,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra1,
  input  logic [DATA_W-1:0] rd1,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = $clog2(READ_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_REGS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [LAT_W-1:0]  lat_cnt, lat_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic [ADDR_W-1:0] hold_idx, hold_idx_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      lat_cnt   <= '0;
      hold_data <= '0;
      hold_idx  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      lat_cnt   <= lat_n;
      hold_data <= hold_data_n;
      hold_idx  <= hold_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    lat_n       = lat_cnt;
    hold_data_n = hold_data;
    hold_idx_n  = hold_idx;
    ra1         = '0;
    we3         = 1'b0;
    wa3         = '0;
    wd3         = '0;
    dout_valid  = 1'b0;
    din_ready   = 1'b0;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_dump) begin
          state_n = RD_ISSUE;
          idx_n   = '0;
        end else if (start_load) begin
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      RD_ISSUE: begin
        ra1     = idx;
        lat_n   = LAT_W'(READ_LAT);
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        ra1   = idx;
        lat_n = lat_cnt - 1'b1;
        // rd1 is valid in the cycle whose edge
        // brings the counter to zero.
        if (lat_cnt <= LAT_W'(1)) begin
          hold_data_n = rd1;
          hold_idx_n  = idx;
          state_n     = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (idx == LAST) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = RD_ISSUE;
          end
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        // Zero register is never written, even if
        // N_REGS is misconfigured.
        we3 = din_valid && (idx != XZR_IDX);
        wa3 = idx;
        wd3 = din_data;
        if (din_valid) begin
          if (idx == LAST) begin
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      DONE: begin
        done    = !abort;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (abort && state != IDLE) begin
      state_n = IDLE;
    end
  end

  assign busy      = (state != IDLE);
  assign dout_data = hold_data;
  assign dout_idx  = hold_idx;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Testbench for reg_dump_ctrl with a registered-read
// behavioural register file model.
module tb_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_dump, start_load, abort;
  logic [4:0]  ra1, wa3, dout_idx;
  logic [63:0] rd1, wd3, dout_data, din_data;
  logic        we3, dout_valid, dout_ready;
  logic        din_valid, din_ready, busy, done;
  logic        preset = 1'b0;

  logic [63:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  reg_dump_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_dump (start_dump),
    .start_load (start_load),
    .abort      (abort),
    .ra1        (ra1),
    .rd1        (rd1),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .dout_data  (dout_data),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'(i);
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
    rd1 <= rf[ra1];
  end

  task automatic do_preset;
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
  endtask

  task automatic pulse_dump;
    @(negedge clk);
    start_dump = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start_dump = 0; start_load = 0; abort = 0;
    dout_ready = 0; din_valid = 0; din_data = '0;
    #1;
    n_checks++;
    if ({busy, done, dout_valid, din_ready, we3} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 00000",
               {busy, done, dout_valid, din_ready, we3});
    end
    n_checks++;
    if ({ra1, wa3, dout_idx} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_addr got %h want 0",
               {ra1, wa3, dout_idx});
    end
    n_checks++;
    if (dout_data !== 64'd0 || wd3 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0",
               dout_data, wd3);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_dump_full;
    int  words = 0;
    bit  got_last = 0;
    bit  bad_ra = 0;
    bit  early_done = 0;
    do_preset();
    dout_ready = 1'b1;
    pulse_dump();
    for (int c = 0; c < 200 && !got_last; c++) begin
      if (ra1 === 5'd31) bad_ra = 1;
      if (done) early_done = 1;
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (dout_idx !== 5'(words) ||
            dout_data !== 64'(words)) begin
          n_fail++;
          $display("FAIL dump_word got (%0d,%0h) want (%0d,%0h)",
                   dout_idx, dout_data, words, words);
        end
        if (words == 30) got_last = 1;
        words++;
      end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!got_last || done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dump_done got done=%b busy=%b want 1/1",
               done, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_after got done=%b busy=%b want 0/0",
               done, busy);
    end
    n_checks++;
    if (words != 31 || bad_ra || early_done) begin
      n_fail++;
      $display("FAIL dump_count got %0d ra31=%0d early=%0d want 31/0/0",
               words, bad_ra, early_done);
    end
  endtask

  task automatic test_stall;
    int words = 0;
    int stall = 0;
    bit fin = 0;
    do_preset();
    dout_ready = 1'b1;
    pulse_dump();
    for (int c = 0; c < 300 && !fin; c++) begin
      if (done) fin = 1;
      dout_ready = !(dout_valid && dout_idx == 5'd5 && stall < 4);
      if (dout_valid && !dout_ready) begin
        stall++;
        n_checks++;
        if (dout_data !== 64'd5 || dout_idx !== 5'd5) begin
          n_fail++;
          $display("FAIL stall_hold got (%0d,%0h) want (5,5)",
                   dout_idx, dout_data);
        end
      end
      if (dout_valid && dout_ready) begin
        if (dout_idx !== 5'(words)) begin
          n_checks++;
          n_fail++;
          $display("FAIL stall_order got %0d want %0d",
                   dout_idx, words);
        end
        words++;
      end
      @(negedge clk); #1;
    end
    dout_ready = 1'b1;
    n_checks++;
    if (stall != 4 || words != 31 || !fin) begin
      n_fail++;
      $display("FAIL stall_count got stall=%0d words=%0d fin=%0d want 4/31/1",
               stall, words, fin);
    end
  endtask

  task automatic test_load;
    int k = 0;
    int pulses = 0;
    bit bad = 0;
    bit fin = 0;
    do_preset();
    din_valid = 1'b0;
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      din_valid = (c % 3) != 2;
      din_data  = 64'hA5A5_0000 + 64'(k);
      #1;
      if (done) fin = 1;
      if (we3) begin
        pulses++;
        if (wa3 !== 5'(k) || wd3 !== din_data) bad = 1;
      end
      if (din_valid && din_ready) k++;
      @(negedge clk);
    end
    din_valid = 1'b0;
    #1;
    n_checks++;
    if (pulses != 31 || bad || !fin) begin
      n_fail++;
      $display("FAIL load_we3 got pulses=%0d bad=%0d fin=%0d want 31/0/1",
               pulses, bad, fin);
    end
    for (int i = 0; i < 31; i++) begin
      n_checks++;
      if (rf[i] !== 64'hA5A5_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL load_reg X%0d got %h want %h",
                 i, rf[i], 64'hA5A5_0000 + 64'(i));
      end
    end
    n_checks++;
    if (rf[31] !== 64'd31) begin
      n_fail++;
      $display("FAIL load_xzr got %h want 1f", rf[31]);
    end
  endtask

  task automatic test_both;
    int words = 0;
    bit rdy_seen = 0;
    bit fin = 0;
    do_preset();
    dout_ready = 1'b1;
    @(negedge clk);
    start_dump = 1'b1;
    start_load = 1'b1;
    @(negedge clk);
    start_dump = 1'b0;
    start_load = 1'b0;
    #1;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (done) fin = 1;
      if (din_ready || we3) rdy_seen = 1;
      if (dout_valid && dout_ready) words++;
      @(negedge clk); #1;
    end
    n_checks++;
    if (words != 31 || rdy_seen || !fin) begin
      n_fail++;
      $display("FAIL both_start got words=%0d din_rdy=%0d fin=%0d want 31/0/1",
               words, rdy_seen, fin);
    end
  endtask

  task automatic test_abort;
    bit found = 0;
    bit done_seen = 0;
    do_preset();
    dout_ready = 1'b1;
    pulse_dump();
    for (int c = 0; c < 200 && !found; c++) begin
      if (dout_valid && dout_idx == 5'd10) begin
        found = 1;
        abort = 1'b1;
        dout_ready = 1'b0;
      end else begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_checks++;
    if (!found || busy !== 1'b0 || dout_valid !== 1'b0 ||
        done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle got found=%0d busy=%b dv=%b done=%b want 1/0/0/0",
               found, busy, dout_valid, done);
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (done) done_seen = 1;
    end
    n_checks++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL abort_nodone got done pulse want none");
    end
    dout_ready = 1'b1;
    pulse_dump();
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (dout_valid) found = 1;
      else begin
        @(negedge clk); #1;
      end
    end
    n_checks++;
    if (!found || dout_idx !== 5'd0 || dout_data !== 64'd0) begin
      n_fail++;
      $display("FAIL abort_restart got (%0d,%0h) want (0,0)",
               dout_idx, dout_data);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_load;
    int k = 0;
    do_preset();
    din_valid = 1'b0;
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (k == 7) break;
      din_valid = 1'b1;
      din_data  = 64'hA5A5_0000 + 64'(k);
      #1;
      if (din_valid && din_ready) k++;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (k != 7 ||
        {busy, done, dout_valid, din_ready, we3} !== 5'b0 ||
        {ra1, wa3} !== 10'b0 || wd3 !== 64'd0) begin
      n_fail++;
      $display("FAIL midrst_out got k=%0d ctl=%b ra1=%0d wa3=%0d want 7/00000/0/0",
               k, {busy, done, dout_valid, din_ready, we3},
               ra1, wa3);
    end
    @(negedge clk);
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 31; i++) begin
      logic [63:0] exp;
      exp = (i < 7) ? 64'hA5A5_0000 + 64'(i) : 64'(i);
      n_checks++;
      if (rf[i] !== exp) begin
        n_fail++;
        $display("FAIL midrst_reg X%0d got %h want %h",
                 i, rf[i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dump_full();
    test_stall();
    test_load();
    test_both();
    test_abort();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
